// File: rtl/alu_nibble_serial.sv
// Nibble-serial ALU: processes one 4-bit slice per clock, LSB nibble first,
// with optional BCD correction for ADD/SUB and an accumulator write-back.
module alu_nibble_serial #(
  parameter int WIDTH  = 8,
  parameter bit DEC_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             n_RES,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             DEC,
  input  logic             WR_AC,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RES,
  output logic             ACR,
  output logic             AVR,
  output logic             ZR,
  output logic             NR,
  output logic [WIDTH-1:0] AC
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_EOR   = 3'd4;
  localparam logic [2:0] OP_SR    = 3'd5;
  localparam logic [2:0] OP_PASSA = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry;

  logic [WIDTH-1:0] a_q, b_q, work;
  logic [2:0]       op_q;
  logic             cin_q, dec_q, wr_q;

  logic [CW+1:0]    base;
  logic [3:0]       nib_a, nib_b, nib_bx, bin, nib;
  logic [4:0]       sum;
  logic             ovf, arith;
  logic [WIDTH-1:0] shr, next_work;

  // bx is already inverted for SUB; returns {carry, nibble} after optional BCD fix-up
  function automatic logic [4:0] nib_arith(input logic [3:0] a, input logic [3:0] bx,
                                           input logic c, input logic sub, input logic dec);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, bx} + {4'b0000, c};
    if (dec && !sub && (s > 5'd9)) return {1'b1, s[3:0] + 4'd6};
    if (dec && sub && !s[4])       return {1'b0, s[3:0] - 4'd6};
    return s;
  endfunction

  always_comb begin
    base   = {cnt, 2'b00};
    nib_a  = a_q[base +: 4];
    nib_b  = b_q[base +: 4];
    arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    nib_bx = (op_q == OP_SUB) ? ~nib_b : nib_b;
    sum    = nib_arith(nib_a, nib_bx, carry, op_q == OP_SUB, dec_q);
    // overflow is judged on the uncorrected binary sum of the slice
    bin    = nib_a + nib_bx + {3'b000, carry};
    ovf    = (nib_a[3] == nib_bx[3]) && (bin[3] != nib_a[3]);
    shr    = {cin_q, a_q[WIDTH-1:1]};
    case (op_q)
      OP_ADD, OP_SUB: nib = sum[3:0];
      OP_AND:         nib = nib_a & nib_b;
      OP_OR:          nib = nib_a | nib_b;
      OP_EOR:         nib = nib_a ^ nib_b;
      OP_SR:          nib = shr[base +: 4];
      OP_PASSA:       nib = nib_a;
      OP_PASSB:       nib = nib_b;
      default:        nib = nib_a;
    endcase
    next_work = work;
    next_work[base +: 4] = nib;
  end

  // Operand latches and partial result: no reset needed, qualified by state
  always_ff @(posedge CLK) begin
    if (state == IDLE && START) begin
      a_q   <= A;
      b_q   <= B;
      op_q  <= OP;
      cin_q <= CIN;
      dec_q <= DEC & DEC_EN;
      wr_q  <= WR_AC;
    end
    if (state == RUN) work <= next_work;
  end

  // Sequencer and architected outputs
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      RES   <= '0;
      ACR   <= 1'b0;
      AVR   <= 1'b0;
      ZR    <= 1'b0;
      NR    <= 1'b0;
      AC    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state <= RUN;
            cnt   <= '0;
            carry <= CIN;
            BUSY  <= 1'b1;
          end
        end
        RUN: begin
          carry <= sum[4];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            RES   <= next_work;
            ACR   <= arith ? sum[4] : ((op_q == OP_SR) ? a_q[0] : 1'b0);
            AVR   <= arith & ovf;
            ZR    <= (next_work == '0);
            NR    <= next_work[WIDTH-1];
            if (wr_q) AC <= next_work;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Self-checking bench for alu_nibble_serial: vector table, randomized ops
// against a word-level reference model, and hand-written timing sequences.
module tb_alu_nibble_serial;

  logic        CLK, n_RES, START, CIN, DEC, WR_AC;
  logic [2:0]  OP;
  logic [15:0] A16, B16;

  logic        busy8, done8, acr8, avr8, zr8, nr8;
  logic [7:0]  res8, ac8;
  logic        busynd, donend, acrnd, avrnd, zrnd, nrnd;
  logic [7:0]  resnd, acnd;
  logic        busy16, done16, acr16, avr16, zr16, nr16;
  logic [15:0] res16, ac16;

  alu_nibble_serial #(.WIDTH(8), .DEC_EN(1'b1)) dut8 (
    .CLK(CLK), .n_RES(n_RES), .START(START), .OP(OP), .A(A16[7:0]), .B(B16[7:0]),
    .CIN(CIN), .DEC(DEC), .WR_AC(WR_AC), .BUSY(busy8), .DONE(done8), .RES(res8),
    .ACR(acr8), .AVR(avr8), .ZR(zr8), .NR(nr8), .AC(ac8));

  alu_nibble_serial #(.WIDTH(8), .DEC_EN(1'b0)) dutnd (
    .CLK(CLK), .n_RES(n_RES), .START(START), .OP(OP), .A(A16[7:0]), .B(B16[7:0]),
    .CIN(CIN), .DEC(DEC), .WR_AC(WR_AC), .BUSY(busynd), .DONE(donend), .RES(resnd),
    .ACR(acrnd), .AVR(avrnd), .ZR(zrnd), .NR(nrnd), .AC(acnd));

  alu_nibble_serial #(.WIDTH(16), .DEC_EN(1'b1)) dut16 (
    .CLK(CLK), .n_RES(n_RES), .START(START), .OP(OP), .A(A16), .B(B16),
    .CIN(CIN), .DEC(DEC), .WR_AC(WR_AC), .BUSY(busy16), .DONE(done16), .RES(res16),
    .ACR(acr16), .AVR(avr16), .ZR(zr16), .NR(nr16), .AC(ac16));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat8, latnd, lat16, dn8, dnnd, dn16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] res;
    logic        acr;
    logic        avr;
  } mres_t;

  // Word-level reference: binary ops on whole words, BCD digit by digit
  function automatic mres_t model(input int w, input bit dec_en, input logic [2:0] op,
                                  input logic [31:0] a_in, input logic [31:0] b_in,
                                  input logic cin, input logic dec);
    mres_t r;
    logic [31:0] mask, a, b, bb, binres;
    logic [32:0] s;
    int c, x, y, t, dig;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    a = a_in & mask;
    b = b_in & mask;
    r.res = '0; r.acr = 1'b0; r.avr = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        bb = (op == 3'd1) ? (~b & mask) : b;
        s = {1'b0, a} + {1'b0, bb} + {32'h0, cin};
        binres = s[31:0] & mask;
        r.avr = (a[w-1] == bb[w-1]) && (binres[w-1] != a[w-1]);
        if (!(dec && dec_en)) begin
          r.res = binres;
          r.acr = s[w];
        end else begin
          c = int'(cin);
          for (int i = 0; i < w / 4; i++) begin
            x = int'((a >> (4 * i)) & 32'hF);
            y = int'((bb >> (4 * i)) & 32'hF);
            t = x + y + c;
            if (op == 3'd0) begin
              if (t > 9) begin dig = (t + 6) & 15; c = 1; end
              else begin dig = t; c = 0; end
            end else begin
              if (t < 16) begin dig = (t - 6) & 15; c = 0; end
              else begin dig = t & 15; c = 1; end
            end
            r.res = r.res | (32'(dig) << (4 * i));
          end
          r.acr = (c != 0);
        end
      end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: begin r.res = (a >> 1) | ({31'h0, cin} << (w - 1)); r.acr = a[0]; end
      3'd6: r.res = a;
      default: r.res = b;
    endcase
    return r;
  endfunction

  // Accept edge, then watch 8 edges recording first DONE edge and pulse counts
  task automatic collect();
    @(posedge CLK); #1;
    START = 1'b0;
    lat8 = -1; latnd = -1; lat16 = -1; dn8 = 0; dnnd = 0; dn16 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (done8)  begin dn8++;  if (lat8  < 0) lat8  = k; end
      if (donend) begin dnnd++; if (latnd < 0) latnd = k; end
      if (done16) begin dn16++; if (lat16 < 0) lat16 = k; end
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic dec, input logic wr);
    OP = op; A16 = a; B16 = b; CIN = cin; DEC = dec; WR_AC = wr; START = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic dec, input logic wr);
    @(negedge CLK);
    drive(op, a, b, cin, dec, wr);
    collect();
  endtask

  task automatic settle();
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1;
      if (!busy8 && !busynd && !busy16) break;
    end
    chk("idle_after_settle", {29'h0, busy8, busynd, busy16}, 32'h0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       cin, dec;
    logic [7:0] res;
    logic       acr, avr;
  } vec_t;

  vec_t vecs[13];
  mres_t m;
  logic [7:0]  ac_exp8, ac_expnd;
  logic [15:0] ac_exp16;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1};
    vecs[2]  = '{3'd1, 8'h12, 8'h21, 1'b1, 1'b1, 8'h91, 1'b0, 1'b0};
    vecs[3]  = '{3'd5, 8'h81, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0};
    vecs[4]  = '{3'd1, 8'h50, 8'h30, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0};
    vecs[5]  = '{3'd1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6]  = '{3'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 8'hF0, 8'h0C, 1'b1, 1'b0, 8'hFC, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 8'hA5, 8'h11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[11] = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{3'd5, 8'h02, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};

    n_RES = 1'b0; START = 1'b0; OP = 3'd0; A16 = '0; B16 = '0;
    CIN = 1'b0; DEC = 1'b0; WR_AC = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs8", {busy8, done8, acr8, avr8, zr8, nr8, res8, ac8}, 32'h0);
    chk("reset_outputs16", {busy16, done16, res16}, 32'h0);
    @(negedge CLK);
    n_RES = 1'b1;
    ac_exp8 = '0; ac_expnd = '0; ac_exp16 = '0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin, vecs[i].dec, 1'b1);
      chk($sformatf("vec%0d_res", i), 32'(res8), 32'(vecs[i].res));
      chk($sformatf("vec%0d_acr", i), 32'(acr8), 32'(vecs[i].acr));
      chk($sformatf("vec%0d_avr", i), 32'(avr8), 32'(vecs[i].avr));
      chk($sformatf("vec%0d_zr_nr", i), {30'h0, zr8, nr8},
          {30'h0, vecs[i].res == 8'h00, vecs[i].res[7]});
      chk($sformatf("vec%0d_ac", i), 32'(ac8), 32'(vecs[i].res));
      chk($sformatf("vec%0d_latency", i), 32'(lat8), 32'd2);
      chk($sformatf("vec%0d_done_pulses", i), 32'(dn8), 32'd1);
      m = model(8, 1'b0, vecs[i].op, {24'h0, vecs[i].a}, {24'h0, vecs[i].b}, vecs[i].cin, vecs[i].dec);
      chk($sformatf("vec%0d_nodec_res_acr", i), {23'h0, acrnd, resnd}, {23'h0, m.acr, m.res[7:0]});
      ac_exp8 = vecs[i].res; ac_expnd = m.res[7:0];
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op; logic [15:0] a, b; logic cin, dec, wr;
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); dec = 1'($urandom); wr = 1'($urandom);
      run_op(op, a, b, cin, dec, wr);
      m = model(8, 1'b1, op, {16'h0, a}, {16'h0, b}, cin, dec);
      if (wr) ac_exp8 = m.res[7:0];
      chk($sformatf("rnd%0d_w8", i), {21'h0, acr8, avr8, zr8, nr8, res8, 1'b0},
          {21'h0, m.acr, m.avr, m.res[7:0] == 8'h0, m.res[7], m.res[7:0], 1'b0});
      chk($sformatf("rnd%0d_w8_ac_lat", i), {ac8, 24'(lat8)}, {ac_exp8, 24'd2});
      m = model(8, 1'b0, op, {16'h0, a}, {16'h0, b}, cin, dec);
      if (wr) ac_expnd = m.res[7:0];
      chk($sformatf("rnd%0d_nodec", i), {14'h0, acrnd, avrnd, resnd, acnd},
          {14'h0, m.acr, m.avr, m.res[7:0], ac_expnd});
      m = model(16, 1'b1, op, {16'h0, a}, {16'h0, b}, cin, dec);
      if (wr) ac_exp16 = m.res[15:0];
      chk($sformatf("rnd%0d_w16", i), {12'h0, acr16, avr16, zr16, nr16, res16},
          {12'h0, m.acr, m.avr, m.res[15:0] == 16'h0, m.res[15], m.res[15:0]});
      chk($sformatf("rnd%0d_w16_ac_lat", i), {ac16, 16'(lat16)}, {ac_exp16, 16'd4});
    end

    // START pulsed during RUN with different operands must be ignored
    @(negedge CLK);
    drive(3'd0, 16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    A16 = 16'h0077;
    lat8 = -1; dn8 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (k == 1) START = 1'b0;
      if (done8) begin dn8++; if (lat8 < 0) lat8 = k; end
    end
    chk("ignore_start_done_pulses", 32'(dn8), 32'd1);
    chk("ignore_start_latency", 32'(lat8), 32'd2);
    chk("ignore_start_res", 32'(res8), 32'h11);
    settle();

    // Back-to-back: START held through the DONE cycle
    @(negedge CLK);
    drive(3'd0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk("b2b_busy_after_accept", 32'(busy8), 32'd1);
    @(posedge CLK); #1;
    chk("b2b_no_early_done", 32'(done8), 32'd0);
    @(posedge CLK); #1;
    chk("b2b_first_done", {done8, res8}, {1'b1, 8'h03});
    OP = 3'd1; A16 = 16'h0009; B16 = 16'h0003; CIN = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("b2b_second_accepted", {done8, busy8}, {1'b0, 1'b1});
    @(posedge CLK); #1;
    chk("b2b_second_not_yet", {done8, res8}, {1'b0, 8'h03});
    @(posedge CLK); #1;
    chk("b2b_second_done", {done8, res8, acr8}, {1'b1, 8'h06, 1'b1});
    settle();

    // 16-bit carry ripple through all four nibbles
    run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("w16_ffff_res", 32'(res16), 32'h0);
    chk("w16_ffff_flags", {zr16, acr16, avr16, nr16}, {1'b1, 1'b1, 1'b0, 1'b0});
    chk("w16_ffff_latency", 32'(lat16), 32'd4);

    // Reset mid-operation aborts, then START is accepted on the first edge
    @(negedge CLK);
    drive(3'd0, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    n_RES = 1'b0;
    #1;
    chk("abort_async_clear", {busy8, done8, res8, ac8}, 32'h0);
    @(negedge CLK);
    n_RES = 1'b1;
    drive(3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    collect();
    chk("abort_first_edge_accept_latency", 32'(lat8), 32'd2);
    chk("abort_single_done", 32'(dn8), 32'd1);
    chk("abort_res_ac", {res8, ac8}, {8'h02, 8'h00});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_nibble_serial.md
ALU_NIBBLE_SERIAL -- requirements
Module: alu_nibble_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a multiple of 4 in 8..32; N = WIDTH/4 nibbles.
REQ-002 Parameter DEC_EN, default 1; 1 enables decimal (BCD) correction, 0 forces binary regardless of DEC.
REQ-003 Ports SHALL be, clock and reset first:
  CLK  in  1  sole clock, all state on rising edge
  n_RES  in  1  reset
  START  in  1  request; operands sampled when accepted
  OP  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 SR, 110 PASSA, 111 PASSB
  A  in  WIDTH  operand A
  B  in  WIDTH  operand B
  CIN  in  1  carry-in (ADD/SUB), shift-in MSB (SR)
  DEC  in  1  decimal mode request (ADD/SUB only)
  WR_AC  in  1  write result into AC on completion
  BUSY  out  1  operation in progress
  DONE  out  1  one-cycle completion pulse
  RES  out  WIDTH  result
  ACR  out  1  carry out
  AVR  out  1  signed overflow
  ZR  out  1  RES == 0
  NR  out  1  RES[WIDTH-1]
  AC  out  WIDTH  accumulator
REQ-004 One clock; reset is asynchronous and active-low (n_RES); clock port is CLK.

Function
REQ-005 States SHALL be IDLE and RUN; nibble counter 0..N-1.
REQ-006 In IDLE, START=1 at a rising edge SHALL be accepted: latch A, B, OP, CIN, DEC&DEC_EN, WR_AC; carry register := CIN; counter := 0; go RUN; BUSY=1.
REQ-007 START while in RUN SHALL be ignored; latched operands unchanged.
REQ-008 In RUN each edge SHALL process nibble[counter] (LSB nibble first), write it into the result register, update carry, increment counter.
REQ-009 At the edge processing nibble N-1: go IDLE, BUSY=0, DONE=1 for exactly the following cycle, RES/flags update, AC := result if latched WR_AC; DONE therefore rises N edges after the accepting edge (2 for WIDTH=8).
REQ-010 START=1 in the DONE cycle SHALL be accepted (back-to-back, no gap cycle).
REQ-011 RES, ACR, AVR, ZR, NR SHALL hold their values until the next completion; partial nibbles never appear on RES.
REQ-012 ADD binary nibble: s = a+b+c (5 bits), nibble = s[3:0], carry = s[4].
REQ-013 SUB binary nibble: s = a+~b+c; carry=1 means no borrow.
REQ-014 ADD decimal nibble: s = a+b+c; if s>9 then nibble=(s+6)[3:0], carry=1, else nibble=s, carry=0.
REQ-015 SUB decimal nibble: s = a+~b+c; if s[4]=0 (borrow) nibble=(s-6)[3:0], carry=0, else nibble=s[3:0], carry=1.
REQ-016 AVR for ADD/SUB SHALL be the binary signed overflow of the top nibble (before decimal correction): carry into bit WIDTH-1 XOR carry out of it; AVR=0 for other ops.
REQ-017 ACR SHALL be final carry for ADD/SUB, latched A[0] for SR, 0 otherwise.
REQ-018 SR SHALL produce {CIN, A[WIDTH-1:1]}; logic/pass ops bitwise per nibble; all ops take N cycles.
REQ-019 ZR and NR SHALL be derived from the final (corrected) result.

Reset
REQ-020 n_RES=0 SHALL immediately force IDLE, counter 0, BUSY=0, DONE=0, RES=0, ACR=AVR=ZR=NR=0, AC=0.
REQ-021 Reset during RUN SHALL abort the operation: no DONE, no AC write after release.
REQ-022 After n_RES deasserts, START SHALL be acceptable on the first rising edge.

Verification (WIDTH=8 unless stated)
REQ-023 ADD A=7F B=01 CIN=0 DEC=0 -> RES=80, ACR=0, AVR=1, NR=1, ZR=0, DONE 2 edges after accept.
REQ-024 ADD decimal A=58 B=46 CIN=1 -> RES=05, ACR=1; with DEC_EN=0 same stimulus -> RES=9F, ACR=0.
REQ-025 SUB decimal A=12 B=21 CIN=1 -> RES=91, ACR=0; SR A=81 CIN=1 -> RES=C0, ACR=1.
REQ-026 START pulsed during RUN -> ignored, one DONE only; START held in DONE cycle -> second op accepted, next DONE 2 cycles later.
REQ-027 WR_AC=1 op with n_RES pulsed low after 1 edge -> AC=00, no DONE; WIDTH=16 ADD FFFF+0001 CIN=0 -> RES=0000, ZR=1, ACR=1, DONE 4 edges after accept.
